match_timer: RTL and testbench



---
 rtl/match_timer.sv | 180 ++++++++++++++++++
 tb/tb_match_timer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/match_timer.sv
// match_timer: match countdown clock on the slow clk_26 tick domain.
// Loads a clamped match length while idle, counts down once per tick while
// the game runs, and sequences the game-over hold before reporting done.
//
// Ports:
//   clk_26      slow tick clock
//   reset       asynchronous, active-high
//   run         level from clk domain, high while the main state is game
//   pause       level from clk domain, freezes the countdown
//   game_over   level from clk domain, score-based end of match
//   load_value  requested match length in seconds (sampled only in IDLE)
//   seconds     remaining seconds
//   sec_tens    BCD tens digit of seconds
//   sec_ones    BCD ones digit of seconds
//   expired     level, countdown reached 0
//   warn        level, running with 0 < seconds <= WARN_SECONDS
//   hold_done   one-tick pulse, game-over hold finished
//   state       0 IDLE, 1 COUNT, 2 HOLD, 3 DONE
module match_timer #(
  parameter int unsigned INIT_SECONDS = 60,
  parameter int unsigned MIN_SECONDS  = 10,
  parameter int unsigned MAX_SECONDS  = 99,
  parameter int unsigned WARN_SECONDS = 10,
  parameter int unsigned HOLD_TICKS   = 3
) (
  input  logic       clk_26,
  input  logic       reset,
  input  logic       run,
  input  logic       pause,
  input  logic       game_over,
  input  logic [6:0] load_value,
  output logic [6:0] seconds,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       expired,
  output logic       warn,
  output logic       hold_done,
  output logic [1:0] state
);

  localparam int unsigned CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [6:0]    INIT_V    = 7'(INIT_SECONDS);
  localparam logic [6:0]    MIN_V     = 7'(MIN_SECONDS);
  localparam logic [6:0]    MAX_V     = 7'(MAX_SECONDS);
  localparam logic [6:0]    WARN_V    = 7'(WARN_SECONDS);
  localparam logic [3:0]    INIT_TENS = 4'(INIT_SECONDS / 10);
  localparam logic [3:0]    INIT_ONES = 4'(INIT_SECONDS % 10);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t st, st_nx;

  logic run_m, run_s;
  logic pause_m, pause_s;
  logic over_m, over_s;

  logic [CW-1:0] hold_cnt, hold_cnt_nx;
  logic [6:0]    sec_nx;
  logic [3:0]    tens_nx, ones_nx;
  logic          expired_nx, warn_nx, hold_done_nx;

  logic [6:0]    eff;
  logic [3:0]    eff_tens, eff_ones;

  assign state = st;

  // Two-flop synchronisers for the clk-domain control levels.
  always_ff @(posedge clk_26 or posedge reset) begin
    if (reset) begin
      run_m   <= 1'b0;
      run_s   <= 1'b0;
      pause_m <= 1'b0;
      pause_s <= 1'b0;
      over_m  <= 1'b0;
      over_s  <= 1'b0;
    end else begin
      run_m   <= run;
      run_s   <= run_m;
      pause_m <= pause;
      pause_s <= pause_m;
      over_m  <= game_over;
      over_s  <= over_m;
    end
  end

  always_ff @(posedge clk_26 or posedge reset) begin
    if (reset) begin
      st        <= S_IDLE;
      seconds   <= INIT_V;
      sec_tens  <= INIT_TENS;
      sec_ones  <= INIT_ONES;
      expired   <= 1'b0;
      warn      <= 1'b0;
      hold_done <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      st        <= st_nx;
      seconds   <= sec_nx;
      sec_tens  <= tens_nx;
      sec_ones  <= ones_nx;
      expired   <= expired_nx;
      warn      <= warn_nx;
      hold_done <= hold_done_nx;
      hold_cnt  <= hold_cnt_nx;
    end
  end

  always_comb begin
    // Out-of-range requests fall back to the default match length.
    eff      = (load_value < MIN_V || load_value > MAX_V) ? INIT_V : load_value;
    eff_tens = 4'(eff / 7'd10);
    eff_ones = 4'(eff % 7'd10);

    st_nx        = st;
    sec_nx       = seconds;
    tens_nx      = sec_tens;
    ones_nx      = sec_ones;
    expired_nx   = expired;
    hold_cnt_nx  = hold_cnt;
    hold_done_nx = 1'b0;

    case (st)
      S_IDLE: begin
        sec_nx      = eff;
        tens_nx     = eff_tens;
        ones_nx     = eff_ones;
        expired_nx  = 1'b0;
        hold_cnt_nx = '0;
        if (run_s) st_nx = S_COUNT;
      end
      S_COUNT: begin
        if (!run_s) begin
          st_nx = S_IDLE;
        end else if (over_s) begin
          // game_over outranks the final decrement: seconds stays put.
          st_nx       = S_HOLD;
          hold_cnt_nx = '0;
        end else if (pause_s) begin
          st_nx = S_COUNT;
        end else if (seconds != 7'd0) begin
          sec_nx = seconds - 7'd1;
          if (sec_ones == 4'd0) begin
            ones_nx = 4'd9;
            tens_nx = sec_tens - 4'd1;
          end else begin
            ones_nx = sec_ones - 4'd1;
          end
          if (seconds == 7'd1) begin
            expired_nx  = 1'b1;
            st_nx       = S_HOLD;
            hold_cnt_nx = '0;
          end
        end
      end
      S_HOLD: begin
        if (!run_s) begin
          st_nx = S_IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          st_nx        = S_DONE;
          hold_done_nx = 1'b1;
        end else begin
          hold_cnt_nx = hold_cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (!run_s) st_nx = S_IDLE;
      end
    endcase

    warn_nx = (st_nx == S_COUNT) && (sec_nx != 7'd0) && (sec_nx <= WARN_V);
  end

endmodule

// File: tb/tb_match_timer.sv
// tb_match_timer: directed bench for match_timer with hand-computed
// expectations; a negedge monitor checks the BCD digits against seconds.
module tb_match_timer;

  logic       clk_26 = 1'b0;
  logic       reset;
  logic       run;
  logic       pause;
  logic       game_over;
  logic [6:0] load_value;
  logic [6:0] seconds;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       expired;
  logic       warn;
  logic       hold_done;
  logic [1:0] state;

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          mon_on = 1'b0;

  match_timer #(
    .INIT_SECONDS(60),
    .MIN_SECONDS (10),
    .MAX_SECONDS (99),
    .WARN_SECONDS(10),
    .HOLD_TICKS  (3)
  ) dut (
    .clk_26    (clk_26),
    .reset     (reset),
    .run       (run),
    .pause     (pause),
    .game_over (game_over),
    .load_value(load_value),
    .seconds   (seconds),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .expired   (expired),
    .warn      (warn),
    .hold_done (hold_done),
    .state     (state)
  );

  always #5 clk_26 = ~clk_26;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk_26) begin
    if (mon_on)
      check_eq("bcd_invariant", 32'(sec_tens) * 10 + 32'(sec_ones), 32'(seconds));
  end

  task automatic tick();
    @(posedge clk_26);
    #1;
  endtask

  task automatic expect_out(input string tag, input int unsigned sec, input int unsigned st,
                            input int unsigned exp_e, input int unsigned exp_w,
                            input int unsigned exp_h);
    check_eq({tag, "_sec"},  32'(seconds),  sec);
    check_eq({tag, "_tens"}, 32'(sec_tens), sec / 10);
    check_eq({tag, "_ones"}, 32'(sec_ones), sec % 10);
    check_eq({tag, "_st"},   32'(state),    st);
    check_eq({tag, "_exp"},  32'(expired),  exp_e);
    check_eq({tag, "_warn"}, 32'(warn),     exp_w);
    check_eq({tag, "_hd"},   32'(hold_done), exp_h);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; pause = 1'b0; game_over = 1'b0;
    tick(); tick();
    expect_out("rst", 60, 0, 0, 0, 0);
    @(negedge clk_26);
    reset = 1'b0;
  endtask

  task automatic wait_state(input string tag, input int unsigned s, input int unsigned limit);
    for (int i = 0; i < int'(limit); i++) begin
      tick();
      if (32'(state) == s) break;
    end
    check_eq(tag, 32'(state), s);
  endtask

  // Load in IDLE, raise run and wait for COUNT with the loaded value.
  task automatic start(input logic [6:0] lv, input int unsigned eff, input string tag);
    load_value = lv;
    tick(); tick();
    expect_out({tag, "_idle"}, eff, 0, 0, 0, 0);
    run = 1'b1;
    wait_state({tag, "_to_count"}, 1, 6);
    expect_out({tag, "_cnt"}, eff, 1, 0, (eff <= 10) ? 1 : 0, 0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; pause = 1'b0; game_over = 1'b0;
    load_value = 7'd45;
    mon_on = 1'b1;

    // Basic load and countdown.
    do_reset();
    start(7'd45, 45, "t45");
    tick(); expect_out("t45_d1", 44, 1, 0, 0, 0);
    tick(); expect_out("t45_d2", 43, 1, 0, 0, 0);

    // Load clamp.
    do_reset();
    start(7'd5, 60, "lo");
    do_reset();
    start(7'd100, 60, "hi");
    do_reset();
    start(7'd10, 10, "min");

    // Full countdown, warn window, expiry and hold sequence.
    do_reset();
    start(7'd12, 12, "full");
    for (int k = 11; k >= 1; k--) begin
      tick();
      expect_out("full_run", k, 1, 0, (k <= 10) ? 1 : 0, 0);
    end
    tick(); expect_out("full_zero", 0, 2, 1, 0, 0);
    tick(); expect_out("full_h1",   0, 2, 1, 0, 0);
    tick(); expect_out("full_h2",   0, 2, 1, 0, 0);
    tick(); expect_out("full_done", 0, 3, 1, 0, 1);
    tick(); expect_out("full_done2", 0, 3, 1, 0, 0);
    run = 1'b0;
    wait_state("full_to_idle", 0, 6);

    // Pause: raised two ticks ahead so the freeze lands on 30.
    do_reset();
    start(7'd35, 35, "pz");
    tick(); tick(); tick();
    expect_out("pz_32", 32, 1, 0, 0, 0);
    pause = 1'b1;
    tick(); expect_out("pz_31", 31, 1, 0, 0, 0);
    tick(); expect_out("pz_30", 30, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); expect_out("pz_hold", 30, 1, 0, 0, 0);
    end
    pause = 1'b0;
    tick(); expect_out("pz_lag1", 30, 1, 0, 0, 0);
    tick(); expect_out("pz_lag2", 30, 1, 0, 0, 0);
    tick(); expect_out("pz_29", 29, 1, 0, 0, 0);
    tick(); expect_out("pz_28", 28, 1, 0, 0, 0);

    // game_over freezes at 20 and finishes the hold.
    do_reset();
    start(7'd25, 25, "go");
    tick(); tick(); tick();
    game_over = 1'b1;
    tick(); expect_out("go_21", 21, 1, 0, 0, 0);
    tick(); expect_out("go_20", 20, 1, 0, 0, 0);
    tick(); expect_out("go_hold", 20, 2, 0, 0, 0);
    tick(); expect_out("go_h1", 20, 2, 0, 0, 0);
    tick(); expect_out("go_h2", 20, 2, 0, 0, 0);
    tick(); expect_out("go_done", 20, 3, 0, 0, 1);

    // Dropping run during HOLD returns to IDLE without hold_done.
    do_reset();
    start(7'd25, 25, "ab");
    tick(); tick(); tick();
    game_over = 1'b1;
    tick(); tick(); tick();
    expect_out("ab_hold", 20, 2, 0, 0, 0);
    run = 1'b0;
    tick(); expect_out("ab_h1", 20, 2, 0, 0, 0);
    tick(); expect_out("ab_h2", 20, 2, 0, 0, 0);
    tick(); expect_out("ab_idle", 20, 0, 0, 0, 0);
    tick(); expect_out("ab_reload", 25, 0, 0, 0, 0);
    game_over = 1'b0;

    // game_over coinciding with the final decrement wins.
    do_reset();
    start(7'd10, 10, "race");
    for (int i = 0; i < 7; i++) tick();
    expect_out("race_3", 3, 1, 0, 1, 0);
    game_over = 1'b1;
    tick(); expect_out("race_2", 2, 1, 0, 1, 0);
    tick(); expect_out("race_1", 1, 1, 0, 1, 0);
    tick(); expect_out("race_hold", 1, 2, 0, 0, 0);
    game_over = 1'b0;

    // Asynchronous reset mid-count.
    do_reset();
    start(7'd10, 10, "ar");
    tick(); tick(); tick();
    expect_out("ar_7", 7, 1, 0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    expect_out("ar_now", 60, 0, 0, 0, 0);
    tick();
    expect_out("ar_tick", 60, 0, 0, 0, 0);
    reset = 1'b0;
    run = 1'b0;

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
